// File: rtl/mux4_rr_arbiter.sv
// Four-source arbiter owning the 4:1 one-bit mux select, with bounded grant bursts and a registered data/valid stage.
// Define MUX4_ARB_RR_EN for round-robin arbitration; without it, source 0 has the highest fixed priority.
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic       y_q, y_d;
    logic       valid_q, valid_d;
    logic [1:0] win;
    logic       win_found;
    logic       hold;

`ifdef MUX4_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    // Search starts just after the last winner, so the last winner ends up lowest.
    always_comb begin
        win       = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win       = 2'd0;
        win_found = |req;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) win = 2'(k);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
`ifdef MUX4_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        hold = (state_q == GRANT) && req[sel_q] && (cnt_q < MAX_B);
        if (hold) begin
            cnt_d = cnt_q + 4'd1;
        end else if (win_found) begin
            // Covers both a fresh grant from IDLE and a bubble-free handover.
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            cnt_d   = 4'd1;
`ifdef MUX4_ARB_RR_EN
            ptr_d   = win;
`endif
        end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
        end
        valid_d = |gnt_q;
        y_d     = (|gnt_q) & in[sel_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
`ifdef MUX4_ARB_RR_EN
            ptr_q   <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef MUX4_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign y     = y_q;
    assign valid = valid_q;
    assign busy  = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized bench for mux4_rr_arbiter: a behavioural arbitration model feeds an expected queue that is compared every cycle.
module tb_mux4_rr_arbiter;

    localparam int MB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .in    (in),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid),
        .busy  (busy)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the mux, for how many cycles, and who won last.
    logic [8:0] exp_q[$];
    int         m_own  = -1;
    int         m_cnt  = 0;
    int         m_last = 3;
    logic [1:0] m_sel  = 2'd0;
    logic       m_y    = 1'b0;
    logic       m_valid = 1'b0;

    function automatic int pick(input logic [3:0] r, input int lst);
        bit rr;
`ifdef MUX4_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = rr ? (lst + k) % 4 : k - 1;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [8:0] model_vec();
        logic [3:0] g;
        g = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
        return {g, m_sel, m_y, m_valid, (m_own >= 0)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own   = -1;
            m_cnt   = 0;
            m_last  = 3;
            m_sel   = 2'd0;
            m_y     = 1'b0;
            m_valid = 1'b0;
            exp_q.delete();
            exp_q.push_back(model_vec());
        end else begin
            logic nv, ny;
            int   w;
            nv = (m_own >= 0);
            ny = nv ? in[m_own] : 1'b0;
            if (m_own >= 0 && req[m_own] && m_cnt < MB) begin
                m_cnt = m_cnt + 1;
            end else begin
                w = pick(req, m_last);
                if (w < 0) begin
                    m_own = -1;
                end else begin
                    m_own  = w;
                    m_sel  = 2'(w);
                    m_cnt  = 1;
                    m_last = w;
                end
            end
            m_valid = nv;
            m_y     = ny;
            exp_q.push_back(model_vec());
        end
    end

    // Scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("model_outputs", {23'd0, gnt, sel, y, valid, busy}, {23'd0, e});
        end
    end

    int seq_rr[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    int seq_fix[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int dur;
        rst_n = 1'b0;
        req   = 4'b0000;
        in    = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;

        // Pin the model's arbitration rule
        check("pick_first_after_reset", 32'(pick(4'b1111, 3)), 32'd0);
        check("pick_none", 32'(pick(4'b0000, 2)), 32'hffff_ffff);
`ifdef MUX4_ARB_RR_EN
        check("pick_rr_wrap", 32'(pick(4'b1010, 1)), 32'd3);
`else
        check("pick_fixed", 32'(pick(4'b1010, 1)), 32'd1);
`endif

        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_yvb", 32'({y, valid, busy}), 32'd0);

        // Single requester held three cycles
        in  = 4'b1010;
        req = 4'b0010;
        tick();
        check("single_gnt1", 32'(gnt), 32'b0010);
        check("single_sel1", 32'(sel), 32'd1);
        check("single_valid1", 32'(valid), 32'd0);
        tick();
        check("single_y2", 32'({y, valid}), 32'b11);
        tick();
        check("single_gnt3", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        check("single_release_gnt", 32'(gnt), 32'd0);
        check("single_valid_trails", 32'(valid), 32'd1);
        tick();
        check("single_valid_off", 32'(valid), 32'd0);

        // Burst limit with a lone requester: re-granted without a gap
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("burst_gnt", 32'(gnt), 32'b0100);
            if (i > 0) check("burst_valid", 32'(valid), 32'd1);
        end
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset in the middle of a grant
        req = 4'b1111;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'({gnt, sel, y, valid, busy}), 32'd0);
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'({gnt, valid, busy}), 32'd0);

        // All sources requesting from a fresh reset
        do_reset();
        in  = 4'b1010;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef MUX4_ARB_RR_EN
            check("all_req_sel", 32'(sel), 32'(seq_rr[i]));
            if (i == 5) check("all_req_y", 32'(y), 32'd1);
`else
            check("all_req_sel", 32'(sel), 32'(seq_fix[i]));
            if (i == 5) check("all_req_y", 32'(y), 32'd0);
`endif
            check("all_req_onehot", 32'($countones(gnt)), 32'd1);
        end
        req = 4'b0000;
        tick();

        // Early drop and handover
        do_reset();
        req = 4'b0011;
        tick();
        check("handover_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0010;
        tick();
        check("handover_gnt1", 32'(gnt), 32'b0010);
        check("handover_valid1", 32'(valid), 32'd1);
        tick();
        check("handover_valid2", 32'(valid), 32'd1);
        req = 4'b0000;
        tick();
        tick();

        // Randomized segments of held request patterns
        for (int s = 0; s < 400; s++) begin
            req = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 8);
            for (int c = 0; c < dur; c++) begin
                in = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) req[$urandom_range(0, 3)] = 1'b0;
                tick();
            end
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        req = 4'b0000;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
